// File: rtl/udp_tx_payload_loader_pkg.sv
// Shared constants and helpers for the UDP TX payload loader.
// Holds header lengths, default frame lengths and the payload length rule.
package udp_tx_payload_loader_pkg;

  localparam int IP_HDR_LEN         = 20;
  localparam int UDP_HDR_LEN        = 8;
  localparam int ETH_MIN_IP_PAYLOAD = 46;

  localparam logic [15:0] DEF_DATA_LEN  = 16'd28;
  localparam logic [15:0] DEF_TOTAL_LEN = 16'd48;

  // Reported payload: exact byte count, raised to the minimum when padded.
  function automatic logic [15:0] payload_len(input logic [15:0] cnt,
                                              input logic [15:0] min_len);
    return (cnt < min_len) ? min_len : cnt;
  endfunction

endpackage

// File: rtl/udp_tx_payload_loader_if.sv
// Byte stream from user logic into the UDP TX payload loader.
interface udp_tx_payload_loader_if;

  // A byte transfers on a clock edge where s_valid and s_ready are both high.
  // The source holds s_data/s_last stable while s_valid is high and s_ready low;
  // s_last marks the final byte of a frame and is only meaningful with s_valid.
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/udp_tx_payload_loader_byte_word_packer.sv
// 8->32 packer, first byte in [31:24]; a flush emits the partial word zero-filled.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_flush,
    input  logic        i_clear,
    output logic        o_full,
    output logic [31:0] o_full_word,
    output logic [31:0] o_flush_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_lane;

    assign o_full      = i_valid & (r_lane == 2'd3);
    assign o_full_word = {r_shift, i_data};

    always_comb begin
        o_flush_word = 32'h0;
        case (r_lane)
            2'd1:    o_flush_word = {r_shift[7:0], 24'h0};
            2'd2:    o_flush_word = {r_shift[15:0], 16'h0};
            2'd3:    o_flush_word = {r_shift[23:0], 8'h0};
            default: o_flush_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= 24'h0;
            r_lane  <= 2'd0;
        end else if (i_clear || i_flush || o_full) begin
            r_shift <= 24'h0;
            r_lane  <= 2'd0;
        end else if (i_valid) begin
            r_shift <= {r_shift[15:0], i_data};
            r_lane  <= r_lane + 2'd1;
        end
    end

endmodule

// File: rtl/udp_tx_payload_loader.sv
// Packs a user byte stream into the TX payload RAM, pads short frames,
// then hands the frame to the UDP engine with its lengths and a start pulse.
module udp_tx_payload_loader
    import udp_tx_payload_loader_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int BASE_ADDR   = 1,
    parameter int MAX_PAYLOAD = 1472,
    parameter int MIN_PAYLOAD = ETH_MIN_IP_PAYLOAD - IP_HDR_LEN - UDP_HDR_LEN
) (
    input  logic                  e_rxc,
    input  logic                  reset,
    udp_tx_payload_loader_if.slave s,
    output logic                  ram_wren,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [31:0]           ram_data,
    output logic [15:0]           tx_data_length,
    output logic [15:0]           tx_total_length,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  overflow,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_PAD       = 3'd3,
        ST_LAUNCH    = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_DROP      = 3'd6
    } state_t;

    localparam logic [15:0]       MIN_LEN   = 16'(MIN_PAYLOAD);
    localparam logic [15:0]       MAX_LEN   = 16'(MAX_PAYLOAD);
    localparam logic [15:0]       MIN_WORDS = 16'((MIN_PAYLOAD + 3) / 4);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic              r_s_ready;
    logic              r_ram_wren;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_data;
    logic [15:0]       r_tx_dlen;
    logic [15:0]       r_tx_tlen;
    logic              r_tx_start;
    logic              r_overflow;
    logic [15:0]       r_byte_cnt;
    logic [15:0]       r_word_cnt;

    logic        w_accept;
    logic        w_in_fill;
    logic        w_at_max;
    logic        w_full;
    logic [31:0] w_full_word;
    logic [31:0] w_flush_word;
    logic [15:0] w_words_next;
    logic [15:0] w_payload_len;

    assign w_accept      = s.s_valid & r_s_ready;
    assign w_in_fill     = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign w_at_max      = (r_byte_cnt == MAX_LEN);
    assign w_words_next  = r_word_cnt + {15'd0, w_full};
    assign w_payload_len = payload_len(r_byte_cnt, MIN_LEN);

    byte_word_packer u_packer (
        .clk          (e_rxc),
        .rst          (reset),
        .i_valid      (w_accept & w_in_fill & ~w_at_max),
        .i_data       (s.s_data),
        .i_flush      (r_state == ST_FLUSH),
        .i_clear      (w_accept & w_in_fill & w_at_max),
        .o_full       (w_full),
        .o_full_word  (w_full_word),
        .o_flush_word (w_flush_word)
    );

    always_ff @(posedge e_rxc or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_s_ready  <= 1'b0;
            r_ram_wren <= 1'b0;
            r_ram_addr <= BASE;
            r_ram_data <= 32'h0;
            r_tx_dlen  <= DEF_DATA_LEN;
            r_tx_tlen  <= DEF_TOTAL_LEN;
            r_tx_start <= 1'b0;
            r_overflow <= 1'b0;
            r_byte_cnt <= 16'd0;
            r_word_cnt <= 16'd0;
        end else begin
            r_ram_wren <= 1'b0;
            r_tx_start <= 1'b0;
            r_overflow <= 1'b0;
            // Address advances in the cycle after each write is presented.
            if (r_ram_wren) r_ram_addr <= r_ram_addr + ADDR_W'(1);

            case (r_state)
                ST_IDLE, ST_FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_at_max) begin
                            r_overflow <= 1'b1;
                            r_ram_addr <= BASE;
                            r_byte_cnt <= 16'd0;
                            r_word_cnt <= 16'd0;
                            r_state    <= s.s_last ? ST_IDLE : ST_DROP;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                            if (w_full) begin
                                r_ram_wren <= 1'b1;
                                r_ram_data <= w_full_word;
                                r_word_cnt <= w_words_next;
                            end
                            if (s.s_last) begin
                                r_s_ready <= 1'b0;
                                if (!w_full)                      r_state <= ST_FLUSH;
                                else if (w_words_next < MIN_WORDS) r_state <= ST_PAD;
                                else                               r_state <= ST_LAUNCH;
                            end else begin
                                r_state <= ST_FILL;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    r_ram_wren <= 1'b1;
                    r_ram_data <= w_flush_word;
                    r_word_cnt <= r_word_cnt + 16'd1;
                    r_state    <= (r_word_cnt + 16'd1 < MIN_WORDS) ? ST_PAD : ST_LAUNCH;
                end
                ST_PAD: begin
                    r_ram_wren <= 1'b1;
                    r_ram_data <= 32'h0;
                    r_word_cnt <= r_word_cnt + 16'd1;
                    if (r_word_cnt + 16'd1 >= MIN_WORDS) r_state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    r_tx_dlen  <= w_payload_len + 16'(UDP_HDR_LEN);
                    r_tx_tlen  <= w_payload_len + 16'(UDP_HDR_LEN + IP_HDR_LEN);
                    r_tx_start <= 1'b1;
                    r_state    <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        r_state    <= ST_IDLE;
                        r_s_ready  <= 1'b1;
                        r_ram_addr <= BASE;
                        r_byte_cnt <= 16'd0;
                        r_word_cnt <= 16'd0;
                    end
                end
                ST_DROP: begin
                    r_s_ready <= 1'b1;
                    if (w_accept && s.s_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s.s_ready       = r_s_ready;
    assign ram_wren        = r_ram_wren;
    assign ram_addr        = r_ram_addr;
    assign ram_data        = r_ram_data;
    assign tx_data_length  = r_tx_dlen;
    assign tx_total_length = r_tx_tlen;
    assign tx_start        = r_tx_start;
    assign overflow        = r_overflow;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_udp_tx_payload_loader.sv
// Directed bench for udp_tx_payload_loader: RAM writes go through an expected
// queue, lengths and pulses are checked at fixed points of each frame.
module tb_udp_tx_payload_loader;

    logic        e_rxc = 1'b0;
    logic        reset = 1'b1;
    logic        tx_done = 1'b0;
    logic        ram_wren;
    logic [8:0]  ram_addr;
    logic [31:0] ram_data;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        tx_start;
    logic        overflow;
    logic [2:0]  dbg_state;

    udp_tx_payload_loader_if s_if ();

    udp_tx_payload_loader dut (
        .e_rxc           (e_rxc),
        .reset           (reset),
        .s               (s_if),
        .ram_wren        (ram_wren),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .tx_start        (tx_start),
        .tx_done         (tx_done),
        .overflow        (overflow),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #4 e_rxc = ~e_rxc;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_start  = 0;
    int          n_ovf    = 0;
    logic [40:0] exp_q[$];
    logic [7:0]  frame [0:1535];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input int addr, input logic [31:0] data);
        exp_q.push_back({9'(addr), data});
    endtask

    // Expected RAM image: packed words from frame[0..n-1], zero padded to 5 words.
    task automatic exp_frame(input int n);
        int words;
        logic [31:0] w;
        words = (n + 3) / 4;
        for (int k = 0; k < words; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                w = {w[23:0], ((4 * k + b) < n) ? frame[4 * k + b] : 8'h00};
            push_exp(k + 1, w);
        end
        for (int k = words; k < 5; k++) push_exp(k + 1, 32'h0);
    endtask

    // RAM write monitor
    always @(negedge e_rxc) begin : mon
        logic [40:0] e;
        if (reset === 1'b0) begin
            if (ram_wren === 1'b1) begin
                n_checks++;
                assert (exp_q.size() != 0) n_pass++;
                else $display("FAIL ram_write_extra: observed write 0x%08h @%0d, required no write",
                              ram_data, ram_addr);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ram_write", {23'd0, ram_addr, ram_data}, {23'd0, e});
                end
            end
            if (tx_start === 1'b1) n_start++;
            if (overflow === 1'b1) n_ovf++;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered between a rising edge and the following falling edge.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int waited;
        waited = 0;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        repeat (gap) begin @(posedge e_rxc); #1; end
        s_if.s_data  = d;
        s_if.s_last  = last;
        s_if.s_valid = 1'b1;
        @(negedge e_rxc);
        while (s_if.s_ready !== 1'b1 && waited < 500) begin
            @(posedge e_rxc); #1;
            @(negedge e_rxc);
            waited++;
        end
        if (s_if.s_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_byte_ready: s_ready low for 500 cycles, required high");
        end
        @(posedge e_rxc); #1;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int max_gap);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
            send_byte(frame[i], (i == n - 1), gap);
        end
    endtask

    task automatic wait_start(input string tag, input logic [15:0] dl, input logic [15:0] tl);
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge e_rxc);
            if (tx_start === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_start: tx_start not seen in 100 cycles, required one pulse", tag);
        end else begin
            check({tag, "_data_len"}, tx_data_length, dl);
            check({tag, "_total_len"}, tx_total_length, tl);
        end
        @(posedge e_rxc); #1;
    endtask

    task automatic end_frame(input string tag);
        repeat (2) begin @(posedge e_rxc); #1; end
        tx_done = 1'b1;
        @(posedge e_rxc); #1;
        tx_done = 1'b0;
        @(negedge e_rxc);
        check({tag, "_addr_rewind"}, ram_addr, 9'd1);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        @(posedge e_rxc); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, s_if.s_ready, 1'b0);
        check({tag, "_ram_wren"}, ram_wren, 1'b0);
        check({tag, "_ram_addr"}, ram_addr, 9'd1);
        check({tag, "_ram_data"}, ram_data, 32'h0);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_data_len"}, tx_data_length, 16'd28);
        check({tag, "_total_len"}, tx_total_length, 16'd48);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ready_seen;
        s_if.s_data  = 8'h00;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        repeat (3) @(negedge e_rxc);
        check_reset_values("reset");
        @(posedge e_rxc); #1;
        reset = 1'b0;

        // "HELLO": one full word, one flushed word, three pad words
        frame[0] = 8'h48; frame[1] = 8'h45; frame[2] = 8'h4C; frame[3] = 8'h4C; frame[4] = 8'h4F;
        push_exp(1, 32'h48454C4C);
        push_exp(2, 32'h4F000000);
        push_exp(3, 32'h0);
        push_exp(4, 32'h0);
        push_exp(5, 32'h0);
        send_frame(5, 0);
        wait_start("t1", 16'd26, 16'd46);
        end_frame("t1");
        check("t1_start_count", n_start, 1);

        // 20 aligned bytes: no pad, final write N+1 and tx_start N+2
        for (int i = 0; i < 20; i++) frame[i] = 8'(i);
        exp_frame(20);
        send_frame(20, 0);
        @(negedge e_rxc);
        check("t2_final_write_wren", ram_wren, 1'b1);
        check("t2_final_write_addr", ram_addr, 9'd5);
        @(negedge e_rxc);
        check("t2_start_latency", tx_start, 1'b1);
        check("t2_data_len", tx_data_length, 16'd28);
        check("t2_total_len", tx_total_length, 16'd48);
        @(posedge e_rxc); #1;
        end_frame("t2");
        check("t2_start_count", n_start, 2);

        // exactly MAX_PAYLOAD bytes with s_last on the last one is legal
        for (int i = 0; i < 1473; i++) frame[i] = 8'(i) ^ 8'h5A;
        exp_frame(1472);
        send_frame(1472, 0);
        wait_start("t3a", 16'd1480, 16'd1500);
        end_frame("t3a");
        check("t3a_no_overflow", n_ovf, 0);

        // 1473 bytes: overflow on the last byte, frame dropped
        exp_frame(1472);
        send_frame(1473, 0);
        @(negedge e_rxc);
        check("t3b_overflow_pulse", overflow, 1'b1);
        check("t3b_addr_reset", ram_addr, 9'd1);
        @(negedge e_rxc);
        check("t3b_overflow_one_cycle", overflow, 1'b0);
        repeat (10) @(negedge e_rxc);
        check("t3b_overflow_count", n_ovf, 1);
        check("t3b_no_start", n_start, 3);
        check("t3b_queue_drained", exp_q.size(), 0);
        check("t3b_ready_idle", s_if.s_ready, 1'b1);
        @(posedge e_rxc); #1;

        // back-to-back frames, tx_done held off 200 cycles
        for (int i = 0; i < 8; i++) frame[i] = 8'h10 + 8'(i);
        exp_frame(8);
        send_frame(8, 0);
        wait_start("t4a", 16'd26, 16'd46);
        s_if.s_data  = 8'h20;
        s_if.s_last  = 1'b0;
        s_if.s_valid = 1'b1;
        ready_seen = 0;
        repeat (200) begin
            @(negedge e_rxc);
            if (s_if.s_ready !== 1'b0) ready_seen++;
        end
        check("t4_ready_low_while_waiting", ready_seen, 0);
        check("t4_addr_held", ram_addr, 9'd6);
        check("t4_queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) frame[i] = 8'h20 + 8'(i);
        exp_frame(16);
        @(posedge e_rxc); #1;
        tx_done = 1'b1;
        @(posedge e_rxc); #1;
        tx_done = 1'b0;
        send_frame(16, 0);
        wait_start("t4b", 16'd26, 16'd46);
        end_frame("t4b");
        check("t4_start_count", n_start, 5);

        // reset in the middle of a frame
        for (int i = 0; i < 7; i++) frame[i] = 8'(i + 1);
        push_exp(1, 32'h01020304);
        for (int i = 0; i < 7; i++) send_byte(frame[i], 1'b0, 0);
        @(posedge e_rxc); #3;
        reset = 1'b1;
        @(negedge e_rxc);
        check_reset_values("t5_reset");
        check("t5_queue_drained", exp_q.size(), 0);
        @(posedge e_rxc); #1;
        reset = 1'b0;
        push_exp(1, 32'hAABBCCDD);
        push_exp(2, 32'h0);
        push_exp(3, 32'h0);
        push_exp(4, 32'h0);
        push_exp(5, 32'h0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b0, 0);
        send_byte(8'hDD, 1'b1, 0);
        wait_start("t5", 16'd26, 16'd46);
        end_frame("t5");

        // 37 bytes with random s_valid gaps
        for (int i = 0; i < 37; i++) frame[i] = 8'h80 + 8'(i);
        exp_frame(37);
        send_frame(37, 3);
        wait_start("t6", 16'd45, 16'd65);
        end_frame("t6");
        check("t6_start_count", n_start, 7);
        check("final_overflow_count", n_ovf, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
